neo_bit_encoder: RTL
====================

// Module: neo_bit_encoder
// PURPOSE
//  Serial line stage between the strand controller and the NeoPixel data pin.
//  Accepts 24-bit GRB pixel words over a valid/ready handshake and drives the
//  self-clocked WS2812 waveform, MSB first, with a 50 us latch gap after each packet.
//  A one-word holding register keeps back-to-back words gapless on the line.
// PARAMETERS
//  T0H_CYC   18    clocks high for a 0 bit (0.36 us at 50 MHz)
//  T0L_CYC   45    clocks low for a 0 bit
//  T1H_CYC   35    clocks high for a 1 bit (0.70 us)
//  T1L_CYC   28    clocks low for a 1 bit; every bit is 63 clocks (1.26 us)
//  LATCH_CYC 2500  clocks low after the last word (50 us)
// PORTS
//  clock       in   1       system clock, 50 MHz
//  reset       in   1       synchronous, active-high
//  word_in     in   WORD_W  pixel word {G,R,B}; MSB is sent first
//  word_valid  in   1       word_in and word_last are valid
//  word_last   in   1       word is the final word of a packet
//  word_ready  out  1       encoder accepts a word on this cycle
//  neo_data    out  1       serial line to the strand; registered
//  busy        out  1       any state other than IDLE
//  latch_done  out  1       1-cycle pulse when the latch gap completes
//  underrun    out  1       1-cycle pulse on a starved mid-packet word boundary
// BEHAVIOUR
//  - One clock (clock). Reset is synchronous and active-high. On reset: state IDLE,
//    neo_data=0, busy=0, latch_done=0, underrun=0; holding and shift registers cleared.
//    word_ready=0 while reset is high.
//  - Transfer occurs on posedge when word_valid && word_ready.
//  - word_ready = !hold_full && state!=LATCH; in IDLE it equals 1.
//  - FSM has four states: IDLE, HIGH, LOW, LATCH.
//  - IDLE: an accepted word loads the shift register directly.
//    neo_data rises on the next cycle (latency 1); state goes to HIGH.
//  - In other states an accepted word goes to the holding register; hold_full is set.
//  - HIGH: neo_data=1 for T1H_CYC clocks if the current bit is 1, else T0H_CYC.
//    Then go to LOW.
//  - LOW: neo_data=0 for T1L_CYC or T0L_CYC clocks. On the final LOW clock:
//      - If bits remain in the word: shift left, then go to HIGH.
//      - Else if hold_full: move hold to shift, clear hold_full, go to HIGH.
//        No extra gap cycles.
//      - Else if the current word had last=1: go to LATCH.
//      - Else: pulse underrun and go to LATCH. The packet is treated as ended.
//  - LATCH: neo_data=0 for LATCH_CYC clocks. On the final clock, pulse latch_done
//    and return to IDLE. No words are accepted during LATCH.
//  - A hold-register move and a new acceptance never coincide, because
//    word_ready=0 while hold_full=1.
//  - Phase timer is a single down-counter, $clog2(LATCH_CYC+1) bits wide.
//    It is reloaded with (N-1) on entry to each phase; a phase ends at count 0.
//  - Bit counter runs from WORD_W-1 down to 0; a word ends when it reaches 0.
//  - Reset mid-word: on the next edge neo_data=0 and the word is dropped.
//    Upstream must resend the full packet; the strand sees a truncated frame.
//  - word_valid while word_ready=0: the word is ignored. Upstream holds it stable
//    until accepted.
// CONFIGURATION
//  - NEO_RGBW_EN defined: WORD_W=32 and the word is {G,R,B,W}, for RGBW strands.
//    Bit counter starts at 31.
//  - NEO_RGBW_EN undefined: WORD_W=24, word is {G,R,B}. All timing is identical.
// STRUCTURE
//  - Package neo_pkg holds:
//      - enum neo_enc_state_t {IDLE, HIGH, LOW, LATCH};
//      - localparam WORD_W (24, or 32 under NEO_RGBW_EN);
//      - default timing constants, shared with the strand controller's 2500-cycle wait.
//  - One sub-module, neo_phase_timer: a loadable down-counter with a done flag.
//  - The FSM, shift register and holding register stay in this module.
// TESTING
//  1. One word 24'h800001, last=1 -> bit 23: 35 high / 28 low.
//     Bits 22..1: 18 high / 45 low. Bit 0: 35/28. Then 2500 low and one
//     latch_done pulse. Total 1512+2500 clocks after acceptance.
//  2. Two words offered back-to-back, second with last=1 -> second is accepted
//     during word 1. No extra low clocks at the boundary (bit 0 LOW is exactly
//     28 or 45 clocks). word_ready=0 until the hold drains.
//  3. One word with last=0 and no follow-up -> underrun pulses once on the final
//     LOW clock of bit 0; LATCH follows and latch_done pulses after 2500 clocks.
//  4. Reset asserted for 1 cycle at bit 10 of a word -> next cycle neo_data=0,
//     busy=0, word_ready=1; no latch_done pulse.
//  5. word_valid held high during LATCH -> word_ready=0 throughout.
//     The word is accepted on the cycle after latch_done.
//  6. With NEO_RGBW_EN: 32'hFFFFFFFF, last=1 -> 32 bits of 35/28, then LATCH.

Source files
------------

// File: rtl/neo_pkg.sv
// Shared types and timing for the NeoPixel line encoder.
// NEO_RGBW_EN widens pixel words to 32-bit {G,R,B,W}.
package neo_pkg;

`ifdef NEO_RGBW_EN
  localparam int WORD_W = 32;
`else
  localparam int WORD_W = 24;
`endif

  localparam int BIT_W = $clog2(WORD_W);

  localparam int T0H_CYC   = 18;
  localparam int T0L_CYC   = 45;
  localparam int T1H_CYC   = 35;
  localparam int T1L_CYC   = 28;
  localparam int LATCH_CYC = 2500;

  localparam int TMR_W = $clog2(LATCH_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LATCH
  } neo_enc_state_t;

  function automatic logic [TMR_W-1:0] hi_load(input logic b);
    return b ? TMR_W'(T1H_CYC - 1) : TMR_W'(T0H_CYC - 1);
  endfunction

  function automatic logic [TMR_W-1:0] lo_load(input logic b);
    return b ? TMR_W'(T1L_CYC - 1) : TMR_W'(T0L_CYC - 1);
  endfunction

endpackage

// File: rtl/neo_phase_timer.sv
// Loadable phase down-counter; done while the count sits at zero.
module neo_phase_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/neo_bit_encoder.sv
// WS2812 serial encoder with one-word holding register.
// Define NEO_RGBW_EN for 32-bit RGBW pixel words.
module neo_bit_encoder
  import neo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              neo_data,
  output logic              busy,
  output logic              latch_done,
  output logic              underrun
);

  neo_enc_state_t state;

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] hold_q;
  logic              hold_full;
  logic              hold_last;
  logic              cur_last;
  logic [BIT_W-1:0]  bit_cnt;

  logic              t_load;
  logic [TMR_W-1:0]  t_val;
  logic              t_done;
  logic              accept;
  logic              word_end;

  assign word_ready = !reset && !hold_full && (state != LATCH);
  assign accept     = word_valid && word_ready;
  assign busy       = (state != IDLE);
  assign word_end   = (state == LOW) && t_done && (bit_cnt == '0);
  assign latch_done = !reset && (state == LATCH) && t_done;
  assign underrun   = !reset && word_end && !hold_full && !cur_last;

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          t_load = 1'b1;
          t_val  = hi_load(hold_q[WORD_W-1]);
        end else if (accept) begin
          t_load = 1'b1;
          t_val  = hi_load(word_in[WORD_W-1]);
        end
      end
      HIGH: begin
        if (t_done) begin
          t_load = 1'b1;
          t_val  = lo_load(shift_q[WORD_W-1]);
        end
      end
      LOW: begin
        if (t_done) begin
          t_load = 1'b1;
          if (bit_cnt != '0) begin
            t_val = hi_load(shift_q[WORD_W-2]);
          end else if (hold_full) begin
            t_val = hi_load(hold_q[WORD_W-1]);
          end else begin
            t_val = TMR_W'(LATCH_CYC - 1);
          end
        end
      end
      LATCH: begin
        t_load = 1'b0;
      end
    endcase
  end

  neo_phase_timer #(
    .W(TMR_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      neo_data  <= 1'b0;
      shift_q   <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      cur_last  <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      if (accept && state != IDLE) begin
        hold_q    <= word_in;
        hold_last <= word_last;
        hold_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          // A word parked just as the last packet ended starts first
          if (hold_full) begin
            shift_q   <= hold_q;
            cur_last  <= hold_last;
            hold_full <= 1'b0;
            bit_cnt   <= BIT_W'(WORD_W - 1);
            neo_data  <= 1'b1;
            state     <= HIGH;
          end else if (accept) begin
            shift_q  <= word_in;
            cur_last <= word_last;
            bit_cnt  <= BIT_W'(WORD_W - 1);
            neo_data <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (t_done) begin
            neo_data <= 1'b0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (t_done) begin
            if (bit_cnt != '0) begin
              shift_q  <= shift_q << 1;
              bit_cnt  <= bit_cnt - 1'b1;
              neo_data <= 1'b1;
              state    <= HIGH;
            end else if (hold_full) begin
              shift_q   <= hold_q;
              cur_last  <= hold_last;
              hold_full <= 1'b0;
              bit_cnt   <= BIT_W'(WORD_W - 1);
              neo_data  <= 1'b1;
              state     <= HIGH;
            end else begin
              state <= LATCH;
            end
          end
        end
        LATCH: begin
          if (t_done) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
